// File: rtl/priv_1_12_csr_file_if.sv
// priv_1_12_csr_file_if: software CSR access channel between the pipeline (master) and the CSR file (slave).
interface priv_1_12_csr_file_if;
  logic [11:0] csr_addr;
  logic [1:0]  curr_privilege_level;
  logic        csr_write;
  logic        csr_set;
  logic        csr_clear;
  logic        csr_read_only;
  logic        valid_write;
  logic [31:0] new_csr_val;
  logic [31:0] old_csr_val;
  logic        invalid_csr;
  modport master (
    output csr_addr, curr_privilege_level, csr_write, csr_set, csr_clear, csr_read_only, valid_write, new_csr_val,
    input  old_csr_val, invalid_csr
  );
  modport slave (
    input  csr_addr, curr_privilege_level, csr_write, csr_set, csr_clear, csr_read_only, valid_write, new_csr_val,
    output old_csr_val, invalid_csr
  );
endinterface

// File: rtl/priv_1_12_csr_file.sv
// priv_1_12_csr_file: machine-mode CSRs, trap injection and 64-bit counters; PRIV_HPM_COUNTERS_EN adds mhpmcounter3/4.
module priv_1_12_csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
  parameter logic [31:0] MARCHID_VAL = 32'h0
) (
  input  logic                CLK,
  input  logic                RST,
  priv_1_12_csr_file_if.slave csr,
  input  logic                inst_ret,
  input  logic                inject_mstatus,
  input  logic                inject_mepc,
  input  logic                inject_mcause,
  input  logic                inject_mtval,
  input  logic                inject_mip,
  input  logic [31:0]         next_mstatus,
  input  logic [31:0]         next_mepc,
  input  logic [31:0]         next_mcause,
  input  logic [31:0]         next_mtval,
  input  logic [31:0]         next_mip,
  input  logic [31:0]         next_mie,
`ifdef PRIV_HPM_COUNTERS_EN
  input  logic                hpm3_inc,
  input  logic                hpm4_inc,
`endif
  output logic [31:0]         curr_mstatus,
  output logic [31:0]         curr_mie,
  output logic [31:0]         curr_mip,
  output logic [31:0]         curr_mepc,
  output logic [31:0]         curr_mcause,
  output logic [31:0]         curr_mtvec,
  output logic [31:0]         curr_mtval
);
  logic [31:0] mscratch, rd, sw_val;
  logic [63:0] mcycle, minstret;
  logic        hit, any_op, commit;
  logic [11:0] wa;
`ifdef PRIV_HPM_COUNTERS_EN
  logic [63:0] hpm3, hpm4;
`endif
  function automatic logic [31:0] mstatus_warl(input logic [31:0] v);
    return (v & 32'h0000_0088) | 32'h0000_1800;
  endfunction
  // a write to either half wins over the increment for that cycle
  function automatic logic [63:0] cnt_next(input logic [63:0] c, input logic wl, input logic wh,
                                           input logic inc, input logic [31:0] v);
    return wl ? {c[63:32], v} : wh ? {v, c[31:0]} : c + 64'(inc);
  endfunction
  always_comb begin
    rd  = '0;
    hit = 1'b1;
    case (csr.csr_addr)
      12'h300: rd = curr_mstatus;
      12'h301: rd = MISA_VAL;
      12'h304: rd = curr_mie;
      12'h305: rd = curr_mtvec;
      12'h340: rd = mscratch;
      12'h341: rd = curr_mepc;
      12'h342: rd = curr_mcause;
      12'h343: rd = curr_mtval;
      12'h344: rd = curr_mip;
      12'hB00: rd = mcycle[31:0];
      12'hB80: rd = mcycle[63:32];
      12'hB02: rd = minstret[31:0];
      12'hB82: rd = minstret[63:32];
`ifdef PRIV_HPM_COUNTERS_EN
      12'hB03: rd = hpm3[31:0];
      12'hB83: rd = hpm3[63:32];
      12'hB04: rd = hpm4[31:0];
      12'hB84: rd = hpm4[63:32];
`endif
      12'hF11, 12'hF13, 12'hF14: rd = '0;
      12'hF12: rd = MARCHID_VAL;
      default: hit = 1'b0;
    endcase
  end
  assign any_op          = csr.csr_write | csr.csr_set | csr.csr_clear;
  assign csr.invalid_csr = any_op & (~hit | (csr.csr_addr[9:8] > csr.curr_privilege_level)
                                          | (&csr.csr_addr[11:10] & ~csr.csr_read_only));
  assign csr.old_csr_val = rd;
  assign commit          = csr.valid_write & any_op & ~csr.csr_read_only & ~csr.invalid_csr;
  // 0x000 is unimplemented, so it doubles as "no software write this cycle"
  assign wa              = commit ? csr.csr_addr : 12'h000;
  assign sw_val          = csr.csr_write ? csr.new_csr_val
                         : csr.csr_set   ? rd | csr.new_csr_val
                         :                 rd & ~csr.new_csr_val;
  always_ff @(posedge CLK) begin
    if (RST) begin
      curr_mstatus <= 32'h0000_1800;
      curr_mtvec   <= MTVEC_RESET;
      curr_mie     <= '0;
      curr_mip     <= '0;
      curr_mepc    <= '0;
      curr_mcause  <= '0;
      curr_mtval   <= '0;
      mscratch     <= '0;
      mcycle       <= '0;
      minstret     <= '0;
`ifdef PRIV_HPM_COUNTERS_EN
      hpm3         <= '0;
      hpm4         <= '0;
`endif
    end else begin
      if (inject_mstatus) curr_mstatus <= mstatus_warl(next_mstatus);
      else if (wa == 12'h300) curr_mstatus <= mstatus_warl(sw_val);
      if (inject_mip) begin
        curr_mip <= next_mip;
        curr_mie <= next_mie & 32'h0000_0888;
      end else if (wa == 12'h304) curr_mie <= sw_val & 32'h0000_0888;
      if (wa == 12'h305) curr_mtvec <= {sw_val[31:2], sw_val[1] ? curr_mtvec[1:0] : sw_val[1:0]};
      if (wa == 12'h340) mscratch <= sw_val;
      if (inject_mepc) curr_mepc <= next_mepc & 32'hFFFF_FFFC;
      else if (wa == 12'h341) curr_mepc <= sw_val & 32'hFFFF_FFFC;
      if (inject_mcause) curr_mcause <= next_mcause;
      else if (wa == 12'h342) curr_mcause <= sw_val;
      if (inject_mtval) curr_mtval <= next_mtval;
      else if (wa == 12'h343) curr_mtval <= sw_val;
      mcycle   <= cnt_next(mcycle, wa == 12'hB00, wa == 12'hB80, 1'b1, sw_val);
      minstret <= cnt_next(minstret, wa == 12'hB02, wa == 12'hB82, inst_ret, sw_val);
`ifdef PRIV_HPM_COUNTERS_EN
      hpm3     <= cnt_next(hpm3, wa == 12'hB03, wa == 12'hB83, hpm3_inc, sw_val);
      hpm4     <= cnt_next(hpm4, wa == 12'hB04, wa == 12'hB84, hpm4_inc, sw_val);
`endif
    end
  end
endmodule

// File: tb/tb_priv_1_12_csr_file.sv
// tb_priv_1_12_csr_file: directed and randomized checks of the CSR file against a register-level reference model.
module tb_priv_1_12_csr_file;
  localparam logic [31:0] EXP_MTVEC = 32'h0;
  localparam logic [31:0] EXP_MISA  = 32'h4000_0100;
  localparam logic [31:0] EXP_ARCH  = 32'h0;
  logic CLK = 1'b0;
  logic RST;
  logic inst_ret, inject_mstatus, inject_mepc, inject_mcause, inject_mtval, inject_mip;
  logic [31:0] next_mstatus, next_mepc, next_mcause, next_mtval, next_mip, next_mie;
  logic [31:0] curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_mstatus, m_mie, m_mip, m_mepc, m_mcause, m_mtvec, m_mtval, m_mscratch;
  logic [63:0] m_cyc, m_ins;
  logic [11:0] impl [17] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                            12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
  logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                            12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF12, 12'h302, 12'h7C0};
  priv_1_12_csr_file_if csr ();
  priv_1_12_csr_file dut (
    .CLK(CLK), .RST(RST), .csr(csr), .inst_ret(inst_ret),
    .inject_mstatus(inject_mstatus), .inject_mepc(inject_mepc), .inject_mcause(inject_mcause),
    .inject_mtval(inject_mtval), .inject_mip(inject_mip),
    .next_mstatus(next_mstatus), .next_mepc(next_mepc), .next_mcause(next_mcause),
    .next_mtval(next_mtval), .next_mip(next_mip), .next_mie(next_mie),
`ifdef PRIV_HPM_COUNTERS_EN
    .hpm3_inc(1'b0), .hpm4_inc(1'b0),
`endif
    .curr_mstatus(curr_mstatus), .curr_mie(curr_mie), .curr_mip(curr_mip), .curr_mepc(curr_mepc),
    .curr_mcause(curr_mcause), .curr_mtvec(curr_mtvec), .curr_mtval(curr_mtval)
  );
  initial forever #5 CLK = ~CLK;
  function automatic logic m_impl(input logic [11:0] a);
    foreach (impl[i]) if (impl[i] == a) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return EXP_MISA;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return m_mip;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF12: return EXP_ARCH;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic m_inv();
    logic any;
    any = csr.csr_write | csr.csr_set | csr.csr_clear;
    return any && (!m_impl(csr.csr_addr) || csr.csr_addr[9:8] > csr.curr_privilege_level ||
                   (csr.csr_addr[11:10] == 2'b11 && !csr.csr_read_only));
  endfunction
  task automatic model_step();
    logic com;
    logic [31:0] v, o;
    logic [63:0] c, n;
    if (RST) begin
      m_mstatus = 32'h1800; m_mtvec = EXP_MTVEC;
      m_mie = 0; m_mip = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
      m_cyc = 0; m_ins = 0;
      return;
    end
    com = csr.valid_write && (csr.csr_write | csr.csr_set | csr.csr_clear) && !csr.csr_read_only && !m_inv();
    o = m_read(csr.csr_addr);
    v = csr.csr_write ? csr.new_csr_val : csr.csr_set ? (o | csr.new_csr_val) : (o & ~csr.new_csr_val);
    c = m_cyc + 64'd1;
    n = m_ins + 64'(inst_ret);
    if (com) case (csr.csr_addr)
      12'h300: m_mstatus = (v & 32'h88) | 32'h1800;
      12'h304: m_mie = v & 32'h888;
      12'h305: m_mtvec = (v[1:0] >= 2) ? {v[31:2], m_mtvec[1:0]} : v;
      12'h340: m_mscratch = v;
      12'h341: m_mepc = v & 32'hFFFF_FFFC;
      12'h342: m_mcause = v;
      12'h343: m_mtval = v;
      12'hB00: c = {m_cyc[63:32], v};
      12'hB80: c = {v, m_cyc[31:0]};
      12'hB02: n = {m_ins[63:32], v};
      12'hB82: n = {v, m_ins[31:0]};
      default: ;
    endcase
    m_cyc = c;
    m_ins = n;
    if (inject_mstatus) m_mstatus = (next_mstatus & 32'h88) | 32'h1800;
    if (inject_mepc) m_mepc = next_mepc & 32'hFFFF_FFFC;
    if (inject_mcause) m_mcause = next_mcause;
    if (inject_mtval) m_mtval = next_mtval;
    if (inject_mip) begin m_mip = next_mip; m_mie = next_mie & 32'h888; end
  endtask
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask
  task automatic idle();
    csr.csr_addr = 12'h000; csr.curr_privilege_level = 2'b11;
    csr.csr_write = 0; csr.csr_set = 0; csr.csr_clear = 0; csr.csr_read_only = 0; csr.valid_write = 0;
    csr.new_csr_val = 0; inst_ret = 0;
    inject_mstatus = 0; inject_mepc = 0; inject_mcause = 0; inject_mtval = 0; inject_mip = 0;
    next_mstatus = 0; next_mepc = 0; next_mcause = 0; next_mtval = 0; next_mip = 0; next_mie = 0;
  endtask
  task automatic op(input logic [11:0] a, input logic w, input logic s, input logic c, input logic [31:0] v);
    csr.csr_addr = a; csr.csr_write = w; csr.csr_set = s; csr.csr_clear = c;
    csr.valid_write = 1; csr.new_csr_val = v;
  endtask
  task automatic test_reset();
    idle();
    RST = 1;
    op(12'h300, 1, 0, 0, 32'hFFFF_FFFF);
    inject_mepc = 1; next_mepc = 32'h1234;
    tick();
    RST = 0;
    idle();
    #1;
    n_checks++;
    if (curr_mstatus !== 32'h1800) begin n_fail++; $display("FAIL reset_mstatus: got %h want %h", curr_mstatus, 32'h1800); end
    n_checks++;
    if (curr_mtvec !== EXP_MTVEC) begin n_fail++; $display("FAIL reset_mtvec: got %h want %h", curr_mtvec, EXP_MTVEC); end
    n_checks++;
    if ({curr_mcause, curr_mepc, curr_mie, curr_mip, curr_mtval} !== 160'h0) begin
      n_fail++; $display("FAIL reset_zero: mcause %h mepc %h mie %h mip %h mtval %h want 0", curr_mcause, curr_mepc, curr_mie, curr_mip, curr_mtval);
    end
    n_checks++;
    if (csr.invalid_csr !== 1'b0) begin n_fail++; $display("FAIL reset_invalid: got %b want 0", csr.invalid_csr); end
    csr.csr_addr = 12'hB80;
    #1;
    n_checks++;
    if (csr.old_csr_val !== 32'h0) begin n_fail++; $display("FAIL reset_mcycleh: got %h want 0", csr.old_csr_val); end
  endtask
  task automatic test_mstatus_warl();
    idle(); op(12'h300, 1, 0, 0, 32'hFFFF_FFFF); tick();
    n_checks++;
    if (curr_mstatus !== 32'h1888) begin n_fail++; $display("FAIL mstatus_write: got %h want %h", curr_mstatus, 32'h1888); end
    idle(); op(12'h300, 0, 0, 1, 32'hFFFF_FFFF); tick();
    n_checks++;
    if (curr_mstatus !== 32'h1800) begin n_fail++; $display("FAIL mstatus_clear: got %h want %h", curr_mstatus, 32'h1800); end
    idle(); op(12'h301, 1, 0, 0, 32'h0); #1;
    n_checks++;
    if ({csr.invalid_csr, csr.old_csr_val} !== {1'b0, EXP_MISA}) begin
      n_fail++; $display("FAIL misa_read: got inv %b val %h want inv 0 val %h", csr.invalid_csr, csr.old_csr_val, EXP_MISA);
    end
    tick();
  endtask
  task automatic test_mie_set_clear();
    idle(); op(12'h304, 0, 1, 0, 32'h888); tick();
    idle(); op(12'h304, 0, 0, 1, 32'h008); tick();
    n_checks++;
    if (curr_mie !== 32'h880) begin n_fail++; $display("FAIL mie_set_clear: got %h want %h", curr_mie, 32'h880); end
    idle(); op(12'h304, 1, 1, 1, 32'hFFFF_FFFF); tick();
    n_checks++;
    if (curr_mie !== 32'h888) begin n_fail++; $display("FAIL mie_op_priority: got %h want %h", curr_mie, 32'h888); end
  endtask
  task automatic test_mtvec();
    idle(); op(12'h305, 1, 0, 0, 32'h1003); tick();
    n_checks++;
    if (curr_mtvec !== 32'h1000) begin n_fail++; $display("FAIL mtvec_mode3: got %h want %h", curr_mtvec, 32'h1000); end
    idle(); op(12'h305, 1, 0, 0, 32'h2001); tick();
    idle(); op(12'h305, 1, 0, 0, 32'h3002); tick();
    n_checks++;
    if (curr_mtvec !== 32'h3001) begin n_fail++; $display("FAIL mtvec_mode2: got %h want %h", curr_mtvec, 32'h3001); end
  endtask
  task automatic test_collision();
    idle(); op(12'h341, 1, 0, 0, 32'h400); inject_mepc = 1; next_mepc = 32'h200; tick();
    n_checks++;
    if (curr_mepc !== 32'h200) begin n_fail++; $display("FAIL mepc_collision: got %h want %h", curr_mepc, 32'h200); end
    idle(); op(12'h341, 1, 0, 0, 32'h403); tick();
    n_checks++;
    if (curr_mepc !== 32'h400) begin n_fail++; $display("FAIL mepc_align: got %h want %h", curr_mepc, 32'h400); end
    idle(); op(12'h344, 1, 0, 0, 32'hFFFF_FFFF); tick();
    n_checks++;
    if (curr_mip !== 32'h0) begin n_fail++; $display("FAIL mip_sw_ignored: got %h want 0", curr_mip); end
    idle(); op(12'h304, 1, 0, 0, 32'h8); inject_mip = 1; next_mip = 32'h80; next_mie = 32'hFFFF_FFFF; tick();
    n_checks++;
    if ({curr_mip, curr_mie} !== {32'h80, 32'h888}) begin
      n_fail++; $display("FAIL mip_inject: got mip %h mie %h want mip 00000080 mie 00000888", curr_mip, curr_mie);
    end
  endtask
  task automatic test_counters();
    idle(); op(12'hB00, 1, 0, 0, 32'hFFFF_FFFF); tick();
    idle(); op(12'hB80, 1, 0, 0, 32'h0); tick();
    idle(); tick();
    csr.csr_addr = 12'hB80; #1;
    n_checks++;
    if (csr.old_csr_val !== 32'h1) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h want 1", csr.old_csr_val); end
    csr.csr_addr = 12'hB00; #1;
    n_checks++;
    if (csr.old_csr_val !== 32'h0) begin n_fail++; $display("FAIL mcycle_carry_lo: got %h want 0", csr.old_csr_val); end
    idle(); op(12'hB00, 1, 0, 0, 32'hFFFF_FFFF); tick();
    idle(); op(12'hB80, 1, 0, 0, 32'hFFFF_FFFF); tick();
    idle(); tick();
    csr.csr_addr = 12'hB80; #1;
    n_checks++;
    if (csr.old_csr_val !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap: got %h want 0", csr.old_csr_val); end
    idle(); op(12'hB02, 1, 0, 0, 32'hFFFF_FFFE); inst_ret = 1; tick();
    idle(); inst_ret = 1; tick(); tick();
    idle(); tick();
    csr.csr_addr = 12'hB02; #1;
    n_checks++;
    if (csr.old_csr_val !== 32'h0) begin n_fail++; $display("FAIL minstret_lo: got %h want 0", csr.old_csr_val); end
    csr.csr_addr = 12'hB82; #1;
    n_checks++;
    if (csr.old_csr_val !== m_read(12'hB82)) begin n_fail++; $display("FAIL minstret_hi: got %h want %h", csr.old_csr_val, m_read(12'hB82)); end
  endtask
  task automatic test_invalid();
    logic [223:0] snap;
    idle(); tick();
    snap = {curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval};
    op(12'hF11, 1, 0, 0, 32'hFFFF_FFFF); #1;
    n_checks++;
    if (csr.invalid_csr !== 1'b1) begin n_fail++; $display("FAIL ro_write_invalid: got %b want 1", csr.invalid_csr); end
    tick();
    idle(); op(12'h300, 0, 0, 1, 32'hFFFF_FFFF); csr.curr_privilege_level = 2'b00; #1;
    n_checks++;
    if (csr.invalid_csr !== 1'b1) begin n_fail++; $display("FAIL priv_invalid: got %b want 1", csr.invalid_csr); end
    tick();
    idle(); op(12'h340, 1, 0, 0, 32'hDEAD_BEEF); csr.valid_write = 0; tick();
    n_checks++;
    if ({curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval} !== snap) begin
      n_fail++; $display("FAIL invalid_no_change: got %h want %h", {curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval}, snap);
    end
    idle(); csr.csr_addr = 12'h340; #1;
    n_checks++;
    if (csr.old_csr_val !== m_read(12'h340)) begin n_fail++; $display("FAIL stall_no_write: got %h want %h", csr.old_csr_val, m_read(12'h340)); end
    op(12'hF12, 0, 1, 0, 32'h0); csr.csr_read_only = 1; #1;
    n_checks++;
    if ({csr.invalid_csr, csr.old_csr_val} !== {1'b0, EXP_ARCH}) begin
      n_fail++; $display("FAIL ro_read_ok: got inv %b val %h want inv 0 val %h", csr.invalid_csr, csr.old_csr_val, EXP_ARCH);
    end
    tick();
`ifndef PRIV_HPM_COUNTERS_EN
    idle(); op(12'hB03, 0, 1, 0, 32'h0); csr.csr_read_only = 1; #1;
    n_checks++;
    if ({csr.invalid_csr, csr.old_csr_val} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL hpm_absent: got inv %b val %h want inv 1 val 0", csr.invalid_csr, csr.old_csr_val);
    end
    tick();
`endif
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      idle();
      csr.csr_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : pool[$urandom_range(0, 15)];
      csr.curr_privilege_level = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
      csr.csr_write = 1'($urandom); csr.csr_set = 1'($urandom); csr.csr_clear = 1'($urandom);
      csr.csr_read_only = ($urandom_range(0, 5) == 0);
      csr.valid_write = ($urandom_range(0, 4) != 0);
      csr.new_csr_val = $urandom;
      inst_ret = 1'($urandom);
      inject_mstatus = ($urandom_range(0, 7) == 0); next_mstatus = $urandom;
      inject_mepc = ($urandom_range(0, 7) == 0); next_mepc = $urandom;
      inject_mcause = ($urandom_range(0, 7) == 0); next_mcause = $urandom;
      inject_mtval = ($urandom_range(0, 7) == 0); next_mtval = $urandom;
      inject_mip = ($urandom_range(0, 7) == 0); next_mip = $urandom; next_mie = $urandom;
      #1;
      n_checks++;
      if ({csr.invalid_csr, csr.old_csr_val} !== {m_inv(), m_read(csr.csr_addr)}) begin
        n_fail++; $display("FAIL rand_read[%0d] addr %h: got inv %b val %h want inv %b val %h", i, csr.csr_addr,
                           csr.invalid_csr, csr.old_csr_val, m_inv(), m_read(csr.csr_addr));
      end
      tick();
      n_checks++;
      if ({curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval} !==
          {m_mstatus, m_mie, m_mip, m_mepc, m_mcause, m_mtvec, m_mtval}) begin
        n_fail++; $display("FAIL rand_state[%0d]: got %h want %h", i,
                           {curr_mstatus, curr_mie, curr_mip, curr_mepc, curr_mcause, curr_mtvec, curr_mtval},
                           {m_mstatus, m_mie, m_mip, m_mepc, m_mcause, m_mtvec, m_mtval});
      end
    end
  endtask
  initial begin
    RST = 1;
    idle();
    test_reset();
    test_mstatus_warl();
    test_mie_set_clear();
    test_mtvec();
    test_collision();
    test_counters();
    test_invalid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
